// File: rtl/mem_pkg.sv
// Shared definitions for the RV32 memory-access stage: control-bundle field
// positions, memory command encodings and the MEM/WB register layout.
package mem_pkg;

    localparam int MEM_CMD_MSB = 4;
    localparam int MEM_CMD_LSB = 3;
    localparam int WB_CTRL_MSB = 2;
    localparam int WB_CTRL_LSB = 0;

    localparam logic [1:0] MEM_CMD_NONE  = 2'b00;
    localparam logic [1:0] MEM_CMD_STORE = 2'b01;
    localparam logic [1:0] MEM_CMD_LOAD  = 2'b10;

    // 3 + 4*32 = 131 bits carried from MEM to WB
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] pc4;
        logic [31:0] mem_data;
        logic [31:0] alu_data;
    } wb_fields_t;

    localparam wb_fields_t WB_RESET = '0;

endpackage

// File: rtl/mem_stage_if.sv
// Bus between EX/MEM, data memory and WB for mem_stage.
// The stall input exists only when MEM_WB_STALL_EN is defined.
interface mem_stage_if;
    logic [4:0]  ctrl_mem;
    logic [31:0] rd_mem;
    logic [31:0] pc4_mem;
    logic [31:0] alu_result;
    logic [31:0] write_data1;
    logic [31:0] read_data;
`ifdef MEM_WB_STALL_EN
    logic        stall;
`endif
    logic [2:0]  ctrl_wb;
    logic [31:0] rd_wb;
    logic [31:0] pc4_wb;
    logic [31:0] mem_data;
    logic [31:0] alu_data;
    logic [1:0]  mem_ctrl_input;
    logic [31:0] address;
    logic [31:0] w_data;

    // master: the surrounding pipeline/memory; slave: the stage itself
    modport master (
        output ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1, read_data,
`ifdef MEM_WB_STALL_EN
        output stall,
`endif
        input  ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data,
        input  mem_ctrl_input, address, w_data
    );

    modport slave (
        input  ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1, read_data,
`ifdef MEM_WB_STALL_EN
        input  stall,
`endif
        output ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data,
        output mem_ctrl_input, address, w_data
    );
endinterface

// File: rtl/mem_wb_reg.sv
// 131-bit MEM/WB pipeline register, asynchronous active-high clear.
// With MEM_WB_STALL_EN defined, stall holds the contents; reset still wins.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef MEM_WB_STALL_EN
    input  logic       stall,
`endif
    input  wb_fields_t d,
    output wb_fields_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= WB_RESET;
        end
`ifdef MEM_WB_STALL_EN
        else if (!stall) begin
            q <= d;
        end
`else
        else begin
            q <= d;
        end
`endif
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline with the MEM/WB register.
// Optional hold input enabled by MEM_WB_STALL_EN.
module mem_stage
    import mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_stage_if.slave   bus
);

    wb_fields_t wb_d;
    wb_fields_t wb_q;

    // Memory-side outputs are pure wires: they follow inputs even during reset
    assign bus.mem_ctrl_input = bus.ctrl_mem[MEM_CMD_MSB:MEM_CMD_LSB];
    assign bus.address        = bus.alu_result;
    assign bus.w_data         = bus.write_data1;

    assign wb_d.ctrl     = bus.ctrl_mem[WB_CTRL_MSB:WB_CTRL_LSB];
    assign wb_d.rd       = bus.rd_mem;
    assign wb_d.pc4      = bus.pc4_mem;
    assign wb_d.mem_data = bus.read_data;
    assign wb_d.alu_data = bus.alu_result;

    mem_wb_reg u_mem_wb_reg (
        .clk   (clk),
        .reset (reset),
`ifdef MEM_WB_STALL_EN
        .stall (bus.stall),
`endif
        .d     (wb_d),
        .q     (wb_q)
    );

    assign bus.ctrl_wb  = wb_q.ctrl;
    assign bus.rd_wb    = wb_q.rd;
    assign bus.pc4_wb   = wb_q.pc4;
    assign bus.mem_data = wb_q.mem_data;
    assign bus.alu_data = wb_q.alu_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, capture and stall vectors.
// Stall vectors are compiled in only with MEM_WB_STALL_EN.
module tb_mem_stage;

    logic clk;
    logic reset;
    int   vec_count;
    int   miscompares;

    mem_stage_if bus ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish before 200000");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctrl, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] wdata, input logic [31:0] rdata);
        bus.ctrl_mem    = ctrl;
        bus.pc4_mem     = pc4;
        bus.alu_result  = alu;
        bus.rd_mem      = rd;
        bus.write_data1 = wdata;
        bus.read_data   = rdata;
    endtask

    task automatic check_wb(input string tag, input logic [2:0] ctrl, input logic [31:0] pc4,
                            input logic [31:0] rdata, input logic [31:0] alu, input logic [31:0] rd);
        check_val({tag, ".ctrl_wb"},  {29'd0, bus.ctrl_wb}, {29'd0, ctrl});
        check_val({tag, ".pc4_wb"},   bus.pc4_wb,   pc4);
        check_val({tag, ".mem_data"}, bus.mem_data, rdata);
        check_val({tag, ".alu_data"}, bus.alu_data, alu);
        check_val({tag, ".rd_wb"},    bus.rd_wb,    rd);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
`ifdef MEM_WB_STALL_EN
        bus.stall = 1'b0;
`endif
        // reset with pass-through observed immediately
        reset = 1'b1;
        drive(5'b00000, 32'd72, 32'd40, 32'd12, 32'd32, 32'd0);
        #1;
        check_wb("rst0", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_val("rst0.address", bus.address, 32'd40);
        check_val("rst0.w_data",  bus.w_data,  32'd32);
        after_edge();
        check_wb("rst1", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // store, release reset
        @(negedge clk);
        reset = 1'b0;
        drive(5'b01111, 32'd56, 32'd48, 32'd20, 32'd7, 32'd2);
        #1;
        check_val("st.mem_ctrl", {30'd0, bus.mem_ctrl_input}, 32'd1);
        check_wb("st.pre", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        after_edge();
        check_wb("st", 3'b111, 32'd56, 32'd2, 32'd48, 32'd20);

        // no-op command
        @(negedge clk);
        drive(5'b00101, 32'd52, 32'd44, 32'd16, 32'd9, 32'd1);
        #1;
        check_val("nop.mem_ctrl", {30'd0, bus.mem_ctrl_input}, 32'd0);
        check_val("nop.address",  bus.address, 32'd44);
        after_edge();
        check_wb("nop", 3'b101, 32'd52, 32'd1, 32'd44, 32'd16);

        // load with all-ones data patterns
        @(negedge clk);
        drive(5'b10110, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd31, 32'hA5A5_5A5A, 32'hFFFF_FFFF);
        #1;
        check_val("ld.mem_ctrl", {30'd0, bus.mem_ctrl_input}, 32'd2);
        check_val("ld.w_data",   bus.w_data, 32'hA5A5_5A5A);
        after_edge();
        check_wb("ld", 3'b110, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd31);

        // async reset between edges, command keeps flowing
        #2;
        reset = 1'b1;
        #1;
        check_wb("arst", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_val("arst.mem_ctrl", {30'd0, bus.mem_ctrl_input}, 32'd2);

        // reset held across an edge with changing inputs
        @(negedge clk);
        drive(5'b01011, 32'd100, 32'd200, 32'd3, 32'd4, 32'd5);
        after_edge();
        check_wb("rhold", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_val("rhold.mem_ctrl", {30'd0, bus.mem_ctrl_input}, 32'd1);

        // first edge after release captures current inputs
        @(negedge clk);
        reset = 1'b0;
        drive(5'b11010, 32'h1234_5678, 32'h0000_0100, 32'd7, 32'd8, 32'hDEAD_BEEF);
        #1;
        check_val("rel.mem_ctrl", {30'd0, bus.mem_ctrl_input}, 32'd3);
        after_edge();
        check_wb("rel", 3'b010, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0100, 32'd7);

        // back-to-back capture
        @(negedge clk);
        drive(5'b00001, 32'd4, 32'd8, 32'd1, 32'd0, 32'h8000_0000);
        after_edge();
        check_wb("b2b", 3'b001, 32'd4, 32'h8000_0000, 32'd8, 32'd1);

`ifdef MEM_WB_STALL_EN
        // stall holds across two edges
        @(negedge clk);
        bus.stall = 1'b1;
        drive(5'b10111, 32'd60, 32'd64, 32'd9, 32'd0, 32'd77);
        after_edge();
        check_wb("stall1", 3'b001, 32'd4, 32'h8000_0000, 32'd8, 32'd1);
        @(negedge clk);
        drive(5'b01100, 32'd68, 32'd72, 32'd10, 32'd0, 32'd78);
        after_edge();
        check_wb("stall2", 3'b001, 32'd4, 32'h8000_0000, 32'd8, 32'd1);
        // reset wins over stall
        #2;
        reset = 1'b1;
        #1;
        check_wb("stall.rst", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.stall = 1'b0;
        after_edge();
        check_wb("stall.rel", 3'b100, 32'd68, 32'd78, 32'd72, 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
